// File: rtl/muldiv_unit_iter.sv
// muldiv_unit_iter: iterative RV32M multiply/divide, radix 2^BITS_PER_CYCLE.
// Ports: CPU_clk, CPU_rst (sync, active-high); MD_Valid/MD_Ready accept
//   MD_Funct3, MD_Op1, MD_Op2; MD_Flush aborts; MD_Busy stalls PC write;
//   MD_Done pulses one cycle; MD_Result holds the last result.
module muldiv_unit_iter #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             CPU_clk,
    input  logic             CPU_rst,
    input  logic             MD_Valid,
    output logic             MD_Ready,
    input  logic [2:0]       MD_Funct3,
    input  logic [WIDTH-1:0] MD_Op1,
    input  logic [WIDTH-1:0] MD_Op2,
    input  logic             MD_Flush,
    output logic             MD_Busy,
    output logic             MD_Done,
    output logic [WIDTH-1:0] MD_Result
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER);
    localparam int K    = BITS_PER_CYCLE;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES    = '1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             neg_p;
    logic             neg_r;

    // request decode
    logic             is_div;
    logic             op1_sgn;
    logic             op2_sgn;
    logic             sa;
    logic             sb;
    logic             div_zero;
    logic             div_ovf;
    logic             special;
    logic             accept;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;
    logic [WIDTH-1:0] spec_res;

    always_comb begin
        op1_sgn = 1'b0;
        op2_sgn = 1'b0;
        unique case (MD_Funct3)
            3'b001, 3'b100, 3'b110: begin
                op1_sgn = 1'b1;
                op2_sgn = 1'b1;
            end
            3'b010:  op1_sgn = 1'b1;
            default: ;
        endcase
        is_div   = MD_Funct3[2];
        sa       = op1_sgn & MD_Op1[WIDTH-1];
        sb       = op2_sgn & MD_Op2[WIDTH-1];
        mag1     = sa ? -MD_Op1 : MD_Op1;
        mag2     = sb ? -MD_Op2 : MD_Op2;
        div_zero = is_div & (MD_Op2 == '0);
        // only DIV/REM (funct3[0]==0) can overflow
        div_ovf  = is_div & ~MD_Funct3[0] &
                   (MD_Op1 == MIN_NEG) & (MD_Op2 == ONES);
        special  = div_zero | div_ovf;
        if (div_zero)
            spec_res = MD_Funct3[1] ? MD_Op1 : ONES;
        else
            spec_res = MD_Funct3[1] ? '0 : MD_Op1;
        accept   = MD_Valid & (state == IDLE) & ~MD_Flush;
    end

    // one iteration: K shift-add steps or K restoring-division steps
    logic [WIDTH+K-1:0] psum;
    logic [WIDTH-1:0]   mul_hi;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH:0]     dt;
    logic [WIDTH-1:0]   dr;
    logic [WIDTH-1:0]   dq;

    always_comb begin
        psum = {{K{1'b0}}, hi};
        for (int j = 0; j < K; j++) begin
            if (lo[j])
                psum = psum + ({{K{1'b0}}, dvs} << j);
        end
        // {hi,lo} acts as a 2W shift register: low multiplier digits
        // leave the bottom while product bits enter from the top
        mul_hi = psum[WIDTH+K-1:K];
        mul_lo = {psum[K-1:0], lo[WIDTH-1:K]};

        dr = hi;
        dq = lo;
        dt = '0;
        for (int j = 0; j < K; j++) begin
            dt = {dr, dq[WIDTH-1]};
            dq = {dq[WIDTH-2:0], 1'b0};
            if (dt >= {1'b0, dvs}) begin
                dt    = dt - {1'b0, dvs};
                dq[0] = 1'b1;
            end
            dr = dt[WIDTH-1:0];
        end
    end

    // sign fix-up
    logic [2*WIDTH-1:0] prod_n;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_res;

    always_comb begin
        prod_n = neg_p ? -{hi, lo} : {hi, lo};
        quo    = neg_p ? -lo : lo;
        rem    = neg_r ? -hi : hi;
        if (op[2])
            fix_res = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            fix_res = prod_n[WIDTH-1:0];
        else
            fix_res = prod_n[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge CPU_clk) begin
        if (CPU_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept)
                    state_nxt = special ? DONE : CALC;
            end
            CALC: begin
                if (MD_Flush)
                    state_nxt = IDLE;
                else if (cnt == CW'(ITER - 1))
                    state_nxt = FIX;
            end
            FIX:     state_nxt = MD_Flush ? IDLE : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CPU_clk) begin
        if (CPU_rst) begin
            cnt       <= '0;
            op        <= '0;
            dvs       <= '0;
            hi        <= '0;
            lo        <= '0;
            neg_p     <= 1'b0;
            neg_r     <= 1'b0;
            MD_Result <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op    <= MD_Funct3;
                        cnt   <= '0;
                        hi    <= '0;
                        neg_p <= sa ^ sb;
                        neg_r <= sa;
                        if (special) begin
                            MD_Result <= spec_res;
                        end else if (is_div) begin
                            lo  <= mag1;
                            dvs <= mag2;
                        end else begin
                            lo  <= mag2;
                            dvs <= mag1;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    hi  <= op[2] ? dr : mul_hi;
                    lo  <= op[2] ? dq : mul_lo;
                end
                FIX: begin
                    if (!MD_Flush)
                        MD_Result <= fix_res;
                end
                default: ;
            endcase
        end
    end

    assign MD_Ready = (state == IDLE);
    assign MD_Busy  = (state == CALC) | (state == FIX);
    assign MD_Done  = (state == DONE);

endmodule

// File: tb/tb_muldiv_unit_iter.sv
// tb_muldiv_unit_iter: random + directed check of muldiv_unit_iter
// with BITS_PER_CYCLE=1 (index 0) and BITS_PER_CYCLE=4 (index 1).
module tb_muldiv_unit_iter;
    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;
    localparam logic [W-1:0] ALL1 = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         valid [2];
    logic         flush [2];
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready [2];
    logic         busy  [2];
    logic         done  [2];
    logic [W-1:0] res   [2];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] last [2];
    int lat_n [2];

    muldiv_unit_iter #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_d1 (
        .CPU_clk(clk), .CPU_rst(rst),
        .MD_Valid(valid[0]), .MD_Ready(ready[0]),
        .MD_Funct3(f3), .MD_Op1(a), .MD_Op2(b),
        .MD_Flush(flush[0]), .MD_Busy(busy[0]),
        .MD_Done(done[0]), .MD_Result(res[0])
    );

    muldiv_unit_iter #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_d4 (
        .CPU_clk(clk), .CPU_rst(rst),
        .MD_Valid(valid[1]), .MD_Ready(ready[1]),
        .MD_Funct3(f3), .MD_Op1(a), .MD_Op2(b),
        .MD_Flush(flush[1]), .MD_Busy(busy[1]),
        .MD_Done(done[1]), .MD_Result(res[1])
    );

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // RISC-V M-extension semantics in plain 64-bit arithmetic
    function automatic logic [W-1:0] model(input logic [2:0] f,
                                           input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint uy = longint'({32'b0, y});
        logic [63:0] p;
        case (f)
            3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 0) return ALL1;
                if (x == MINV && y == ALL1) return x;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: return (y == 0) ? ALL1 : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MINV && y == ALL1) return '0;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_spec(input logic [2:0] f,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        return f[2] && (y == 0 || (!f[0] && x == MINV && y == ALL1));
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return '0;
            1: return ALL1;
            2: return MINV;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic wait_ready(input int d, input string tag);
        int n = 0;
        while (!ready[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, 32'(ready[d]), 1);
    endtask

    // returns cycles from accept edge until MD_Done is seen high
    task automatic wait_done(input int d, output int n);
        n = 1;
        while (!done[d] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input int d, input logic [2:0] f,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input string tag);
        int n;
        logic [W-1:0] e;
        int el;
        e  = model(f, x, y);
        el = is_spec(f, x, y) ? 1 : lat_n[d];
        wait_ready(d, tag);
        f3 = f; a = x; b = y; valid[d] = 1'b1;
        @(posedge clk); #1;
        valid[d] = 1'b0;
        wait_done(d, n);
        chk({tag, "_lat"}, n, el);
        chk({tag, "_res"}, res[d], e);
        chk({tag, "_drdy"}, 32'(ready[d]), 0);
        last[d] = e;
        @(posedge clk); #1;
    endtask

    task automatic b2b(input int d);
        int n;
        wait_ready(d, "b2b");
        f3 = 3'd1; a = MINV; b = MINV; valid[d] = 1'b1;
        @(posedge clk); #1;
        chk("b2b_busy", 32'(busy[d]), 1);
        chk("b2b_nrdy", 32'(ready[d]), 0);
        f3 = 3'd2; a = ALL1; b = 32'd2;
        wait_done(d, n);
        chk("b2b_lat1", n, lat_n[d]);
        chk("b2b_res1", res[d], 32'h4000_0000);
        chk("b2b_drdy", 32'(ready[d]), 0);
        @(posedge clk); #1;
        chk("b2b_idle", 32'(ready[d]), 1);
        chk("b2b_ndone", 32'(done[d]), 0);
        @(posedge clk); #1;
        valid[d] = 1'b0;
        chk("b2b_busy2", 32'(busy[d]), 1);
        wait_done(d, n);
        chk("b2b_lat2", n, lat_n[d]);
        chk("b2b_res2", res[d], ALL1);
        last[d] = ALL1;
        @(posedge clk); #1;
    endtask

    // flush `at` cycles after the accept edge
    task automatic flush_op(input int d, input int at, input string tag);
        int cnt_done = 0;
        wait_ready(d, tag);
        f3 = 3'd5; a = 32'd100; b = 32'd7; valid[d] = 1'b1;
        @(posedge clk); #1;
        valid[d] = 1'b0;
        repeat (at) @(posedge clk);
        #1;
        chk({tag, "_pre"}, 32'(busy[d]), 1);
        flush[d] = 1'b1;
        @(posedge clk); #1;
        flush[d] = 1'b0;
        chk({tag, "_busy"}, 32'(busy[d]), 0);
        chk({tag, "_rdy0"}, 32'(ready[d]), 1);
        chk({tag, "_res"}, res[d], last[d]);
        for (int i = 0; i < 40; i++) begin
            if (done[d]) cnt_done++;
            @(posedge clk); #1;
        end
        chk({tag, "_nodone"}, cnt_done, 0);
        run_op(d, 3'd5, 32'd100, 32'd7, {tag, "_again"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [2:0]   tf [9];
    logic [W-1:0] ta [9];
    logic [W-1:0] tb [9];

    initial begin
        int cnt_done;
        lat_n[0] = 34;
        lat_n[1] = 10;
        valid[0] = 1'b0; valid[1] = 1'b0;
        flush[0] = 1'b0; flush[1] = 1'b0;
        f3 = '0; a = '0; b = '0;
        tf[0] = 3'd3; ta[0] = ALL1;         tb[0] = ALL1;
        tf[1] = 3'd0; ta[1] = ALL1;         tb[1] = ALL1;
        tf[2] = 3'd4; ta[2] = 32'hFFFFFFF9; tb[2] = 32'd2;
        tf[3] = 3'd6; ta[3] = 32'hFFFFFFF9; tb[3] = 32'd2;
        tf[4] = 3'd7; ta[4] = 32'd7;        tb[4] = 32'hFFFFFFFE;
        tf[5] = 3'd5; ta[5] = 32'h1234;     tb[5] = '0;
        tf[6] = 3'd6; ta[6] = 32'h1234;     tb[6] = '0;
        tf[7] = 3'd4; ta[7] = MINV;         tb[7] = ALL1;
        tf[8] = 3'd6; ta[8] = MINV;         tb[8] = ALL1;

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdy", 32'(ready[d]), 1);
            chk("rst_busy", 32'(busy[d]), 0);
            chk("rst_done", 32'(done[d]), 0);
            chk("rst_res", res[d], 0);
        end
        rst = 1'b0;
        last[0] = '0; last[1] = '0;

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 9; i++)
                run_op(d, tf[i], ta[i], tb[i], $sformatf("dir%0d_%0d", d, i));

        for (int d = 0; d < 2; d++) begin
            b2b(d);
            flush_op(d, (d == 0) ? 10 : 5, "flcalc");
            flush_op(d, lat_n[d] - 2, "flfix");
            valid[d] = 1'b1; flush[d] = 1'b1;
            @(posedge clk); #1;
            valid[d] = 1'b0; flush[d] = 1'b0;
            chk("flidle_rdy", 32'(ready[d]), 1);
            chk("flidle_busy", 32'(busy[d]), 0);
            @(posedge clk); #1;
            chk("flidle_done", 32'(done[d]), 0);
        end

        // reset while BITS_PER_CYCLE=1 unit is mid-CALC
        wait_ready(0, "rstc");
        f3 = 3'd3; a = ALL1; b = ALL1; valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rstc_pre", 32'(busy[0]), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rstc_rdy", 32'(ready[d]), 1);
            chk("rstc_busy", 32'(busy[d]), 0);
            chk("rstc_res", res[d], 0);
            chk("rstc_done", 32'(done[d]), 0);
        end
        last[0] = '0; last[1] = '0;
        cnt_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done[0]) cnt_done++;
            @(posedge clk); #1;
        end
        chk("rstc_nodone", cnt_done, 0);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] rf;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(i % 2, rf, ra, rb, $sformatf("rnd%0d_f%0d", i, rf));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
